// File: rtl/warmup2_adder_pkg.sv
// Shared constants and operand/result types for the 3-stage wide adder.
package warmup2_adder_pkg;

  localparam int WIDTH_DEF  = 384;
  localparam int STAGES_DEF = 3;
  localparam int LATENCY    = 3;
  localparam int CW_DEF     = WIDTH_DEF / STAGES_DEF;

  typedef logic [WIDTH_DEF-1:0] operand_t;
  typedef logic [WIDTH_DEF:0]   result_t;
  typedef logic [CW_DEF-1:0]    chunk_t;

endpackage

// File: rtl/warmup2_adder_chunk.sv
// Combinational CW-bit slice adder; one instance per pipeline stage.
module adder_chunk
  import warmup2_adder_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);

  logic [CW:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  assign sum     = total_s[CW-1:0];
  assign cout    = total_s[CW];

endmodule

// File: rtl/warmup2_adder.sv
// Pipelined WIDTH-bit adder with carry-in, one chunk per stage, result 3 edges after start.
// Optional DONE_COUNT_EN adds a 16-bit wrapping count of completed results.
module warmup2_adder
  import warmup2_adder_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             Cin,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic [WIDTH:0]   outC,
`ifdef DONE_COUNT_EN
  output logic [15:0]      done_count,
`endif
  output logic             done
);

  localparam int CW = WIDTH / STAGES;

  logic [CW-1:0]       sum0_s, sum1_s, sum2_s;
  logic                cout0_s, cout1_s, cout2_s;

  logic [CW-1:0]       s1_sum_d, s1_sum_q;
  logic                s1_c_d, s1_c_q, s1_v_d, s1_v_q;
  logic [WIDTH-CW-1:0] s1_a_d, s1_a_q, s1_b_d, s1_b_q;

  logic [2*CW-1:0]     s2_sum_d, s2_sum_q;
  logic                s2_c_d, s2_c_q, s2_v_d, s2_v_q;
  logic [CW-1:0]       s2_a_d, s2_a_q, s2_b_d, s2_b_q;

  logic [WIDTH:0]      outc_d, outc_q;
  logic                done_d, done_q;
`ifdef DONE_COUNT_EN
  logic [15:0]         cnt_d, cnt_q;
`endif

  adder_chunk #(.CW(CW)) u_chunk0 (
    .a(inA[CW-1:0]), .b(inB[CW-1:0]), .cin(Cin), .sum(sum0_s), .cout(cout0_s)
  );
  adder_chunk #(.CW(CW)) u_chunk1 (
    .a(s1_a_q[CW-1:0]), .b(s1_b_q[CW-1:0]), .cin(s1_c_q), .sum(sum1_s), .cout(cout1_s)
  );
  adder_chunk #(.CW(CW)) u_chunk2 (
    .a(s2_a_q), .b(s2_b_q), .cin(s2_c_q), .sum(sum2_s), .cout(cout2_s)
  );

  // Next-state for every stage; the result register holds across bubbles.
  always_comb begin
    s1_sum_d = sum0_s;
    s1_c_d   = cout0_s;
    s1_a_d   = inA[WIDTH-1:CW];
    s1_b_d   = inB[WIDTH-1:CW];
    s1_v_d   = start;

    s2_sum_d = {sum1_s, s1_sum_q};
    s2_c_d   = cout1_s;
    s2_a_d   = s1_a_q[2*CW-1:CW];
    s2_b_d   = s1_b_q[2*CW-1:CW];
    s2_v_d   = s1_v_q;

    done_d   = s2_v_q;
    if (s2_v_q) begin
      outc_d = {cout2_s, sum2_s, s2_sum_q};
    end else begin
      outc_d = outc_q;
    end
`ifdef DONE_COUNT_EN
    if (s2_v_q) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
`endif
  end

  // Pipeline and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      s1_sum_q <= '0;
      s1_c_q   <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_v_q   <= 1'b0;
      s2_sum_q <= '0;
      s2_c_q   <= 1'b0;
      s2_a_q   <= '0;
      s2_b_q   <= '0;
      s2_v_q   <= 1'b0;
      outc_q   <= '0;
      done_q   <= 1'b0;
`ifdef DONE_COUNT_EN
      cnt_q    <= 16'd0;
`endif
    end else begin
      s1_sum_q <= s1_sum_d;
      s1_c_q   <= s1_c_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_v_q   <= s1_v_d;
      s2_sum_q <= s2_sum_d;
      s2_c_q   <= s2_c_d;
      s2_a_q   <= s2_a_d;
      s2_b_q   <= s2_b_d;
      s2_v_q   <= s2_v_d;
      outc_q   <= outc_d;
      done_q   <= done_d;
`ifdef DONE_COUNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign outC = outc_q;
  assign done = done_q;
`ifdef DONE_COUNT_EN
  assign done_count = cnt_q;
`endif

endmodule

// File: tb/tb_warmup2_adder.sv
// Scoreboard bench for warmup2_adder: expected sums queued at issue, checked when due.
module tb_warmup2_adder;
  import warmup2_adder_pkg::*;

  logic     clk;
  logic     resetn;
  logic     start;
  logic     Cin;
  operand_t inA, inB;
  result_t  outC;
  logic     done;
`ifdef DONE_COUNT_EN
  logic [15:0] done_count;
`endif

  typedef struct {
    int      edge_no;
    result_t exp;
  } op_t;

  op_t     sb_q[$];
  result_t last_out;
  int      cyc;
  int      n_checks;
  int      n_fail;
  int      model_cnt;

  warmup2_adder dut (
    .clk(clk), .resetn(resetn), .start(start), .Cin(Cin),
    .inA(inA), .inB(inB), .outC(outC),
`ifdef DONE_COUNT_EN
    .done_count(done_count),
`endif
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input result_t got, input result_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic operand_t rand384();
    operand_t r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic result_t model_sum(input operand_t a, input operand_t b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{WIDTH_DEF{1'b0}}, c};
  endfunction

  // Drive one cycle's inputs, advance one edge, then compare against the scoreboard.
  task automatic cycle(input logic st, input logic c, input operand_t a, input operand_t b,
                       input result_t exp);
    op_t op;
    start = st; Cin = c; inA = a; inB = b;
    if (st && !resetn) begin
      op.edge_no = cyc + 1;
      op.exp     = exp;
      sb_q.push_back(op);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (sb_q.size() > 0 && sb_q[0].edge_no + LATENCY - 1 == cyc) begin
      op = sb_q.pop_front();
      check("done_hi", {{WIDTH_DEF{1'b0}}, done}, 385'd1);
      check("outC", outC, op.exp);
      last_out = op.exp;
      model_cnt++;
    end else begin
      check("done_lo", {{WIDTH_DEF{1'b0}}, done}, 385'd0);
      check("outC_hold", outC, last_out);
    end
  endtask

  task automatic rand_op(input logic st);
    operand_t a, b;
    logic c;
    a = rand384(); b = rand384(); c = 1'($urandom_range(0, 1));
    cycle(st, c, a, b, model_sum(a, b, c));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    operand_t ones;
    result_t  e;
    ones = '1;
    n_checks = 0; n_fail = 0; cyc = 0; model_cnt = 0;
    last_out = '0;
    resetn = 1'b1; start = 1'b0; Cin = 1'b0; inA = '0; inB = '0;

    #12;
    check("rst_outC", outC, '0);
    check("rst_done", {{WIDTH_DEF{1'b0}}, done}, 385'd0);
    resetn = 1'b0;

    cycle(1'b1, 1'b0, '0, '0, '0);
    idle(4);

    rand_op(1'b1);
    rand_op(1'b1);
    idle(3);

    e = '0; e[WIDTH_DEF] = 1'b1;
    cycle(1'b1, 1'b1, ones, '0, e);
    idle(3);

    e = '1;
    cycle(1'b1, 1'b1, ones, ones, e);
    idle(3);

    for (int i = 0; i < 4; i++) rand_op(1'b1);
    idle(5);

    // Reset while two operations are in flight; they must never appear.
    rand_op(1'b1);
    rand_op(1'b1);
    resetn = 1'b1;
    #2;
    check("midrst_outC", outC, '0);
    check("midrst_done", {{WIDTH_DEF{1'b0}}, done}, 385'd0);
    sb_q.delete();
    last_out  = '0;
    model_cnt = 0;
    idle(1);
    resetn = 1'b0;
    idle(2);
    rand_op(1'b1);
    idle(4);

    for (int i = 0; i < 40; i++) rand_op(1'($urandom_range(0, 1)));
    idle(4);
    check("drained", result_t'(sb_q.size()), '0);

`ifdef DONE_COUNT_EN
    check("done_count", {{(WIDTH_DEF-15){1'b0}}, done_count}, result_t'(model_cnt[15:0]));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
